// File: rtl/memory_unit_reader_pkg.sv
// Shared definitions for the MemoryUnit read-side serialiser.
package memory_unit_reader_pkg;

    // Word width shared with MemoryUnit din/dout.
    localparam int MEM_WORD_W = 35;

    // Reader FSM encodings; fixed values so a bound checker or waveform
    // viewer can decode dbg_state directly.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/memory_unit_reader.sv
// Read-side companion to MemoryUnit: snapshots mem_dout on a read request,
// then streams the word one bit per accepted beat over a valid/ready port,
// reporting word parity and a one-cycle done pulse after the last bit.
//
// Serial handshake: a bit transfers on every rising clk edge where
// ser_valid & ser_ready are both high. ser_valid rises the cycle after the
// accepted rden and stays high until the final bit (ser_last) transfers; it
// never depends combinationally on ser_ready. While ser_ready is low,
// ser_out and ser_last hold their values.
module memory_unit_reader
    import memory_unit_reader_pkg::*;
#(
    parameter int WIDTH     = MEM_WORD_W,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             rden,
    input  logic [WIDTH-1:0] mem_dout,
    output logic             busy,
    output logic [WIDTH-1:0] word_q,
    output logic             parity,
    output logic             ser_out,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_last,
    output logic             done,
    output logic [1:0]       dbg_state
);

    localparam int                CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_sreg;
    logic [WIDTH-1:0] w_sreg_shifted;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_word_q;
    logic             r_parity;
    logic             w_capture;
    logic             w_beat;
    logic             w_cnt_last;

    assign w_cnt_last = (r_cnt == LAST_CNT);

    // Move the next bit toward the end that drives ser_out.
    assign w_sreg_shifted = LSB_FIRST ? (r_sreg >> 1) : (r_sreg << 1);

    // State register.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode plus capture/beat strobes for the datapath.
    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_beat       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (rden) begin
                    w_capture    = 1'b1;
                    w_next_state = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // rden is deliberately not looked at here: requests while busy are dropped.
                w_beat = ser_ready;
                if (ser_ready && w_cnt_last) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Shift register and beat counter; the terminal beat leaves both as-is
    // so the counter never wraps past WIDTH-1.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_sreg <= '0;
            r_cnt  <= '0;
        end else if (w_capture) begin
            r_sreg <= mem_dout;
            r_cnt  <= '0;
        end else if (w_beat && !w_cnt_last) begin
            r_sreg <= w_sreg_shifted;
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    // Word snapshot and parity, held until the next accepted request.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_word_q <= '0;
            r_parity <= 1'b0;
        end else if (w_capture) begin
            r_word_q <= mem_dout;
            r_parity <= ^mem_dout;
        end
    end

    assign ser_out   = LSB_FIRST ? r_sreg[0] : r_sreg[WIDTH-1];
    assign ser_valid = (r_state == ST_SHIFT);
    assign ser_last  = (r_state == ST_SHIFT) && w_cnt_last;
    assign done      = (r_state == ST_DONE);
    assign busy      = (r_state == ST_SHIFT) || (r_state == ST_DONE);
    assign word_q    = r_word_q;
    assign parity    = r_parity;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_memory_unit_reader.sv
// Bench for memory_unit_reader: an LSB-first and an MSB-first instance share
// all inputs and are checked every cycle against a bit-queue reference model,
// plus table-driven reads and hand-written reset / ignored-request sequences.
module tb_memory_unit_reader;

  localparam int W = 35;

  logic         clk = 1'b0;
  logic         arst = 1'b0;
  logic         rden = 1'b0;
  logic [W-1:0] mem_dout = '0;
  logic         ser_ready = 1'b0;

  logic         busy_l, parity_l, ser_out_l, ser_valid_l, ser_last_l, done_l;
  logic [W-1:0] word_q_l;
  logic [1:0]   dbg_state_l;
  logic         busy_m, parity_m, ser_out_m, ser_valid_m, ser_last_m, done_m;
  logic [W-1:0] word_q_m;
  logic [1:0]   dbg_state_m;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  memory_unit_reader #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .arst(arst), .rden(rden), .mem_dout(mem_dout),
    .busy(busy_l), .word_q(word_q_l), .parity(parity_l),
    .ser_out(ser_out_l), .ser_valid(ser_valid_l), .ser_ready(ser_ready),
    .ser_last(ser_last_l), .done(done_l), .dbg_state(dbg_state_l)
  );

  memory_unit_reader #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .arst(arst), .rden(rden), .mem_dout(mem_dout),
    .busy(busy_m), .word_q(word_q_m), .parity(parity_m),
    .ser_out(ser_out_m), .ser_valid(ser_valid_m), .ser_ready(ser_ready),
    .ser_last(ser_last_m), .done(done_m), .dbg_state(dbg_state_m)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A read is a queue of bits still to send; a beat pops one.
  logic         m_shift = 1'b0;
  logic         m_done  = 1'b0;
  logic [W-1:0] m_word  = '0;
  logic         m_par   = 1'b0;
  logic [0:0]   exp_q_lsb[$];
  logic [0:0]   exp_q_msb[$];

  always @(posedge clk or posedge arst) begin
    if (arst) begin
      m_shift = 1'b0;
      m_done  = 1'b0;
      m_word  = '0;
      m_par   = 1'b0;
      exp_q_lsb.delete();
      exp_q_msb.delete();
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_shift) begin
      if (ser_ready) begin
        void'(exp_q_lsb.pop_front());
        void'(exp_q_msb.pop_front());
        if (exp_q_lsb.size() == 0) begin
          m_shift = 1'b0;
          m_done  = 1'b1;
        end
      end
    end else if (rden) begin
      int ones;
      ones   = 0;
      m_word = mem_dout;
      for (int i = 0; i < W; i++) begin
        ones += int'(mem_dout[i]);
        exp_q_lsb.push_back(mem_dout[i]);
        exp_q_msb.push_back(mem_dout[W-1-i]);
      end
      m_par   = logic'(ones % 2);
      m_shift = 1'b1;
    end
  end

  task automatic check_dut(input string tag, input logic busy, input logic valid,
                           input logic done, input logic [W-1:0] wq, input logic par,
                           input logic sout, input logic slast, input logic [1:0] st,
                           input int qsize, input logic qhead);
    chk({tag, "_busy"}, 64'(busy), 64'(m_shift | m_done));
    chk({tag, "_ser_valid"}, 64'(valid), 64'(m_shift));
    chk({tag, "_done"}, 64'(done), 64'(m_done));
    chk({tag, "_word_q"}, 64'(wq), 64'(m_word));
    chk({tag, "_parity"}, 64'(par), 64'(m_par));
    chk({tag, "_ser_last"}, 64'(slast), 64'(m_shift && (qsize == 1)));
    chk({tag, "_state"}, 64'(st), m_done ? 64'd2 : (m_shift ? 64'd1 : 64'd0));
    if (m_shift) chk({tag, "_ser_out"}, 64'(sout), 64'(qhead));
  endtask

  // Scoreboard: compare both instances against the model every cycle.
  always @(negedge clk) begin
    check_dut("lsb", busy_l, ser_valid_l, done_l, word_q_l, parity_l, ser_out_l,
              ser_last_l, dbg_state_l, exp_q_lsb.size(),
              (exp_q_lsb.size() > 0) ? exp_q_lsb[0] : 1'b0);
    check_dut("msb", busy_m, ser_valid_m, done_m, word_q_m, parity_m, ser_out_m,
              ser_last_m, dbg_state_m, exp_q_msb.size(),
              (exp_q_msb.size() > 0) ? exp_q_msb[0] : 1'b0);
  end

  // ---------------- driver ----------------
  // mode: 0 ready held high, 1 ready low/high alternating, 2 random ready.
  // noise: random rden while busy, and rden held high across the done cycle.
  // pulse_at: edge index where an all-ones rden request is injected (-1 none).
  // edges: clock edges from the capture edge until done is seen.
  task automatic do_read(input logic [W-1:0] word, input int mode, input int noise,
                         input int pulse_at, output int edges,
                         output logic [4:0] f_lsb, output logic [4:0] f_msb);
    int k;
    int nb_l;
    int nb_m;
    f_lsb = '0;
    f_msb = '0;
    nb_l  = 0;
    nb_m  = 0;
    edges = -1;
    @(negedge clk);
    rden      = 1'b1;
    mem_dout  = word;
    ser_ready = 1'b1;
    @(negedge clk);
    rden = 1'b0;
    k    = 0;
    while (k < 400) begin
      if (done_l) begin
        edges = k;
        break;
      end
      case (mode)
        0:       ser_ready = 1'b1;
        1:       ser_ready = ((k + 1) % 2 == 0);
        default: ser_ready = 1'($urandom_range(0, 1));
      endcase
      mem_dout = {3'($urandom_range(0, 7)), 32'($urandom())};
      rden     = (noise != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (k == pulse_at) begin
        rden     = 1'b1;
        mem_dout = {W{1'b1}};
      end
      if (ser_valid_l && ser_ready && nb_l < 5) begin
        f_lsb = {f_lsb[3:0], ser_out_l};
        nb_l++;
      end
      if (ser_valid_m && ser_ready && nb_m < 5) begin
        f_msb = {f_msb[3:0], ser_out_m};
        nb_m++;
      end
      @(negedge clk);
      k++;
    end
    if (edges < 0) begin
      n_vec++;
      n_err++;
      $display("FAIL done_timeout: no done within %0d cycles, expected done", k);
    end
    rden      = (noise != 0) ? 1'b1 : 1'b0;
    ser_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    rden = 1'b0;
  endtask

  typedef struct {
    logic [W-1:0] word;
    int           mode;
    int           noise;
    logic         exp_par;
    int           exp_edges;
    logic [4:0]   exp_f_lsb;
    logic [4:0]   exp_f_msb;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int         edges;
    logic [4:0] f_l;
    logic [4:0] f_m;

    tbl[0] = '{35'h0_5273_3D13, 0, 0, 1'b0, 35, 5'b11001, 5'b00001};
    tbl[1] = '{35'h0_5273_3D13, 1, 0, 1'b0, 70, 5'b11001, 5'b00001};
    tbl[2] = '{35'h4_0000_0001, 0, 0, 1'b0, 35, 5'b10000, 5'b10000};
    tbl[3] = '{35'h7_FFFF_FFFF, 0, 1, 1'b1, 35, 5'b11111, 5'b11111};
    tbl[4] = '{35'h0_0000_0000, 1, 1, 1'b0, 70, 5'b00000, 5'b00000};
    tbl[5] = '{35'h0_0000_0002, 0, 0, 1'b1, 35, 5'b01000, 5'b00000};

    // Reset with random activity on the inputs.
    #1 arst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rden      = 1'($urandom_range(0, 1));
      mem_dout  = {3'($urandom_range(0, 7)), 32'($urandom())};
      ser_ready = 1'($urandom_range(0, 1));
      #10;
    end
    @(negedge clk);
    rden = 1'b0;
    #2 arst = 1'b0;
    @(negedge clk);
    chk("reset_busy", 64'(busy_l | busy_m), 64'd0);
    chk("reset_word_q", 64'(word_q_l), 64'd0);

    // Table-driven reads.
    for (int t = 0; t < 6; t++) begin
      do_read(tbl[t].word, tbl[t].mode, tbl[t].noise, -1, edges, f_l, f_m);
      chk($sformatf("tbl%0d_edges", t), 64'(edges), 64'(tbl[t].exp_edges));
      chk($sformatf("tbl%0d_first_lsb", t), 64'(f_l), 64'(tbl[t].exp_f_lsb));
      chk($sformatf("tbl%0d_first_msb", t), 64'(f_m), 64'(tbl[t].exp_f_msb));
      chk($sformatf("tbl%0d_parity", t), 64'(parity_l), 64'(tbl[t].exp_par));
      chk($sformatf("tbl%0d_word_q", t), 64'(word_q_m), 64'(tbl[t].word));
    end

    // Request arriving mid-word is dropped.
    do_read(35'h0_5273_3D13, 0, 0, 10, edges, f_l, f_m);
    chk("ignored_word_q", 64'(word_q_l), 64'h0_5273_3D13);
    chk("ignored_edges", 64'(edges), 64'd35);

    // Reset at beat 20 aborts the word without a done pulse.
    @(negedge clk);
    rden      = 1'b1;
    mem_dout  = 35'h0_5273_3D13;
    ser_ready = 1'b1;
    @(negedge clk);
    rden = 1'b0;
    repeat (19) @(negedge clk);
    #2 arst = 1'b1;
    #1;
    chk("midreset_valid", 64'(ser_valid_l | ser_valid_m), 64'd0);
    chk("midreset_busy", 64'(busy_l | busy_m), 64'd0);
    chk("midreset_done", 64'(done_l | done_m), 64'd0);
    chk("midreset_word_q", 64'(word_q_l), 64'd0);
    repeat (2) @(negedge clk);
    #2 arst = 1'b0;
    do_read(35'h0_5273_3D13, 0, 0, -1, edges, f_l, f_m);
    chk("after_reset_edges", 64'(edges), 64'd35);
    chk("after_reset_first", 64'(f_l), 64'(5'b11001));

    // Randomized reads with random backpressure and request noise.
    for (int r = 0; r < 25; r++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_read({3'($urandom_range(0, 7)), 32'($urandom())}, $urandom_range(0, 2),
              $urandom_range(0, 1), -1, edges, f_l, f_m);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
